// File: rtl/cache_control.sv
// Two-way set-associative cache controller: hit service in IDLE, optional dirty-victim
// writeback, line allocate, and a per-state pmem timeout that raises a sticky error.
module cache_control #(
  parameter int unsigned MAX_PMEM_WAIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mem_read,
  input  logic mem_write,
  input  logic tag_match0,
  input  logic tag_match1,
  input  logic valid0,
  input  logic valid1,
  input  logic dirty0,
  input  logic dirty1,
  input  logic lru,
  input  logic pmem_resp,
  output logic mem_resp,
  output logic pmem_read,
  output logic pmem_write,
  output logic load_data0,
  output logic load_data1,
  output logic load_tag0,
  output logic load_tag1,
  output logic set_valid0,
  output logic set_valid1,
  output logic set_dirty0,
  output logic set_dirty1,
  output logic clear_dirty0,
  output logic clear_dirty1,
  output logic load_lru,
  output logic lru_in,
  output logic data_sel,
  output logic pmem_addr_sel,
  output logic way_sel,
  output logic pmem_error
);

  localparam int CNT_W = ($clog2(MAX_PMEM_WAIT + 1) > 8) ? $clog2(MAX_PMEM_WAIT + 1) : 8;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_PMEM_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic             victim, victim_next;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
  logic             error_next;

  logic       hit0, hit1, hit, hit_way, request, victim_dirty, timeout;
  logic [1:0] load_data, load_tag, set_valid, set_dirty, clear_dirty;

  assign hit0         = tag_match0 & valid0;
  assign hit1         = tag_match1 & valid1;
  assign hit          = hit0 | hit1;
  assign hit_way      = ~hit0;  // way 0 wins when both ways hit
  assign request      = mem_read | mem_write;
  assign victim_dirty = lru ? (valid1 & dirty1) : (valid0 & dirty0);
  // The abort fires on the last permitted cycle, so the counter never wraps.
  assign timeout      = (wait_cnt >= LAST_WAIT);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next    = state;
    victim_next   = victim;
    wait_cnt_next = '0;
    error_next    = pmem_error;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    load_data     = 2'b00;
    load_tag      = 2'b00;
    set_valid     = 2'b00;
    set_dirty     = 2'b00;
    clear_dirty   = 2'b00;
    load_lru      = 1'b0;
    lru_in        = 1'b0;
    data_sel      = 1'b0;
    pmem_addr_sel = 1'b0;
    way_sel       = 1'b0;

    unique case (state)
      IDLE: begin
        if (request && hit) begin
          mem_resp = 1'b1;
          load_lru = 1'b1;
          lru_in   = ~hit_way;
          if (mem_write) begin
            load_data[hit_way] = 1'b1;
            set_dirty[hit_way] = 1'b1;
          end
        end else if (request) begin
          victim_next = lru;
          state_next  = victim_dirty ? WRITEBACK : ALLOCATE;
        end
      end

      WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        way_sel       = victim;
        if (pmem_resp) begin
          clear_dirty[victim] = 1'b1;
          state_next          = ALLOCATE;
        end else if (timeout) begin
          error_next = 1'b1;
          state_next = IDLE;
        end else begin
          wait_cnt_next = wait_cnt + 1'b1;
        end
      end

      ALLOCATE: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          data_sel            = 1'b1;
          load_data[victim]   = 1'b1;
          load_tag[victim]    = 1'b1;
          set_valid[victim]   = 1'b1;
          clear_dirty[victim] = 1'b1;
          state_next          = IDLE;
        end else if (timeout) begin
          error_next = 1'b1;
          state_next = IDLE;
        end else begin
          wait_cnt_next = wait_cnt + 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      victim     <= 1'b0;
      wait_cnt   <= '0;
      pmem_error <= 1'b0;
    end else begin
      state      <= state_next;
      victim     <= victim_next;
      wait_cnt   <= wait_cnt_next;
      pmem_error <= error_next;
    end
  end

  assign load_data0   = load_data[0];
  assign load_data1   = load_data[1];
  assign load_tag0    = load_tag[0];
  assign load_tag1    = load_tag[1];
  assign set_valid0   = set_valid[0];
  assign set_valid1   = set_valid[1];
  assign set_dirty0   = set_dirty[0];
  assign set_dirty1   = set_dirty[1];
  assign clear_dirty0 = clear_dirty[0];
  assign clear_dirty1 = clear_dirty[1];

endmodule

// File: doc/cache_control.md
CACHE_CONTROL -- requirements
Module: cache_control

Interface
REQ-001 Parameter: MAX_PMEM_WAIT, default 255, maximum cycles spent waiting for pmem_resp in one memory state before abort.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 mem_read, mem_write  in  1 each  CPU request strobes, held until mem_resp.
REQ-005 tag_match0, tag_match1  in  1 each  tag comparator results for way 0/1 (1 = equal).
REQ-006 valid0, valid1, dirty0, dirty1  in  1 each  indexed-set status bits per way.
REQ-007 lru  in  1  indexed-set LRU bit; value is the way to evict.
REQ-008 pmem_resp  in  1  physical memory completion pulse.
REQ-009 mem_resp  out  1  CPU request complete.
REQ-010 pmem_read, pmem_write  out  1 each  physical memory line read/write requests.
REQ-011 load_data0/1, load_tag0/1, set_valid0/1, set_dirty0/1, clear_dirty0/1  out  1 each  per-way array write enables.
REQ-012 load_lru, lru_in  out  1 each  LRU write enable and value.
REQ-013 data_sel  out  1  line write source: 0 = CPU write merge, 1 = pmem line.
REQ-014 pmem_addr_sel  out  1  0 = CPU address, 1 = victim tag + index (writeback).
REQ-015 way_sel  out  1  way driving data/tag read mux toward pmem.
REQ-016 pmem_error  out  1  sticky timeout flag.

Function
REQ-017 States SHALL be IDLE, WRITEBACK, ALLOCATE; encoding is implementation choice.
REQ-018 hit0 = tag_match0 & valid0, hit1 = tag_match1 & valid1; hit = hit0 | hit1; both hit SHALL resolve to way 0.
REQ-019 Request = mem_read | mem_write; both asserted SHALL be treated as a write.
REQ-020 IDLE, request and hit: SHALL assert mem_resp combinationally same cycle, load_lru=1, lru_in = inverse of hit way; remain IDLE.
REQ-021 IDLE, write hit: additionally load_data and set_dirty of hit way, data_sel=0.
REQ-022 IDLE, request and miss: SHALL latch victim = lru into register; next state WRITEBACK if victim valid&dirty, else ALLOCATE; mem_resp=0.
REQ-023 WRITEBACK: pmem_write=1, pmem_addr_sel=1, way_sel=victim; on pmem_resp SHALL pulse clear_dirty of victim and go to ALLOCATE.
REQ-024 ALLOCATE: pmem_read=1, pmem_addr_sel=0; on pmem_resp SHALL pulse load_data, load_tag, set_valid, clear_dirty of victim with data_sel=1, then go to IDLE.
REQ-025 After ALLOCATE the request SHALL be served as a hit in IDLE (miss latency = memory states + 1 cycle).
REQ-026 Victim register SHALL be stable from miss detection until return to IDLE regardless of lru input changes.
REQ-027 Request deasserted during WRITEBACK/ALLOCATE: transaction SHALL complete normally; no mem_resp issued for a dropped request.
REQ-028 Wait counter (8+ bits, saturating-safe) SHALL clear on every state entry and increment each cycle in WRITEBACK/ALLOCATE without pmem_resp.
REQ-029 Counter reaching MAX_PMEM_WAIT without pmem_resp: SHALL set pmem_error, return to IDLE, issue no array writes; pmem_resp on that same cycle takes precedence (normal completion).
REQ-030 All outputs not named for a state SHALL be 0 in that state; pmem_read and pmem_write SHALL never be asserted together.

Reset
REQ-031 rst_n=0 SHALL force state IDLE, victim=0, counter=0, pmem_error=0 immediately, independent of clk.
REQ-032 Reset mid-WRITEBACK/ALLOCATE SHALL drop pmem_read/pmem_write in the same cycle with no array writes.
REQ-033 After rst_n deasserts, first request SHALL be evaluated at the next rising edge.

Verification
REQ-034 Read hit: mem_read=1, tag_match1=1, valid1=1 -> mem_resp=1 same cycle, load_lru=1, lru_in=0, no pmem activity.
REQ-035 Clean miss: mem_read=1, no match, lru=0, valid0=1, dirty0=0 -> ALLOCATE, pmem_read until pmem_resp after 5 cycles, load_data0/load_tag0/set_valid0 pulse, next cycle hit mem_resp.
REQ-036 Dirty miss: mem_write=1, lru=1, valid1=dirty1=1 -> WRITEBACK with pmem_addr_sel=1, way_sel=1; pmem_resp -> clear_dirty1, ALLOCATE, refill, write hit sets dirty1.
REQ-037 Timeout: MAX_PMEM_WAIT=4, miss, pmem_resp never -> after 4 cycles pmem_error=1, IDLE, no load_* pulses; pmem_error stays 1 until reset.
REQ-038 Async reset mid-ALLOCATE: rst_n low between edges -> pmem_read=0 immediately, state IDLE, pmem_error=0.
REQ-039 Double hit: tag_match0=tag_match1=valid0=valid1=1 write -> load_data0 and set_dirty0 only, lru_in=1.
